// File: rtl/if_fetch_unit_if.sv
// Fetch-unit signal bundle: redirect inputs, instruction-memory handshake and IF/ID outputs.
// The slave modport is the fetch unit; the master modport is its environment.
interface if_fetch_unit_if;
  logic        stall;
  logic        br_take;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jumpr;
  logic [31:0] jr_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        fetch_err;

  modport slave (
    input  stall, br_take, br_target, jump, jump_target, jumpr, jr_addr,
    input  imem_ack, imem_rdata,
    output imem_req, imem_addr,
    output if_id_instr, if_id_pc4, if_id_valid, opcode, funct, fetch_err
  );

  modport master (
    output stall, br_take, br_target, jump, jump_target, jumpr, jr_addr,
    output imem_ack, imem_rdata,
    input  imem_req, imem_addr,
    input  if_id_instr, if_id_pc4, if_id_valid, opcode, funct, fetch_err
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, imem request FSM, one-entry skid buffer and IF/ID register.
// Define IF_FETCH_TIMEOUT_EN to add the S_WAIT timeout counter and sticky fetch_err.
//
// state  | meaning
// S_REQ  | request cycle for pc (imem_req low only straight out of reset)
// S_WAIT | request outstanding, waiting for imem_ack
// S_HOLD | fetched word parked in skid buffer while IF/ID is stalled
module if_fetch_unit (
  input  logic           clk,
  input  logic           rst,
  if_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_req;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc4;
  logic        r_skid_vld;
  logic        r_drop_next;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc4;
  logic        w_timeout;

  always_comb begin
    w_redirect = bus.jumpr | bus.jump | bus.br_take;
    if (bus.jumpr)
      w_target = bus.jr_addr;
    else if (bus.jump)
      w_target = bus.jump_target;
    else
      w_target = bus.br_target;
  end

  assign w_pc4 = r_pc + 32'd4;

`ifdef IF_FETCH_TIMEOUT_EN
  logic [3:0] r_wait_cnt;
  logic       r_err;

  // Fifteenth consecutive S_WAIT cycle without an ack.
  assign w_timeout = (r_state == S_WAIT) && !bus.imem_ack && (r_wait_cnt == 4'd14);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == S_WAIT) && !bus.imem_ack && !w_redirect && !w_timeout)
        r_wait_cnt <= r_wait_cnt + 4'd1;
      else
        r_wait_cnt <= 4'd0;
      if (w_timeout && !w_redirect)
        r_err <= 1'b1;
    end
  end

  assign bus.fetch_err = r_err;
`else
  assign w_timeout     = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= 32'd0;
      r_req        <= 1'b0;
      r_instr      <= 32'd0;
      r_pc4        <= 32'd0;
      r_valid      <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_pc4   <= 32'd0;
      r_skid_vld   <= 1'b0;
      r_drop_next  <= 1'b0;
    end else if (w_redirect) begin
      r_pc       <= {w_target[31:2], 2'b00};
      r_instr    <= 32'd0;
      r_valid    <= 1'b0;
      r_skid_vld <= 1'b0;
      r_state    <= S_REQ;
      r_req      <= 1'b1;
      // A request abandoned in S_WAIT still owes us an ack that must be thrown away.
      case (r_state)
        S_WAIT:  r_drop_next <= !bus.imem_ack || r_drop_next;
        S_REQ:   r_drop_next <= r_drop_next && !bus.imem_ack;
        default: r_drop_next <= r_drop_next;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          r_state <= S_WAIT;
          r_req   <= 1'b1;
          if (bus.imem_ack)
            r_drop_next <= 1'b0;
        end
        S_WAIT: begin
          if (bus.imem_ack) begin
            if (r_drop_next) begin
              r_drop_next <= 1'b0;
              r_state     <= S_REQ;
              r_req       <= 1'b1;
            end else if (!bus.stall) begin
              r_instr <= bus.imem_rdata;
              r_pc4   <= w_pc4;
              r_valid <= 1'b1;
              r_pc    <= w_pc4;
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end else begin
              r_skid_instr <= bus.imem_rdata;
              r_skid_pc4   <= w_pc4;
              r_skid_vld   <= 1'b1;
              r_pc         <= w_pc4;
              r_state      <= S_HOLD;
              r_req        <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!bus.stall) begin
            r_instr    <= r_skid_instr;
            r_pc4      <= r_skid_pc4;
            r_valid    <= r_skid_vld;
            r_skid_vld <= 1'b0;
            r_state    <= S_REQ;
            r_req      <= 1'b1;
          end
        end
        default: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.if_id_instr = r_instr;
  assign bus.if_id_pc4   = r_pc4;
  assign bus.if_id_valid = r_valid;
  assign bus.opcode      = r_instr[31:26];
  assign bus.funct       = r_instr[5:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fetch, stall/skid, redirects, drop, wrap, timeout, reset.
// Timeout expectations follow IF_FETCH_TIMEOUT_EN.
module tb_if_fetch_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

`ifdef IF_FETCH_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  if_fetch_unit_if bus ();

  if_fetch_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_redirect();
    bus.jumpr   = 1'b0;
    bus.jump    = 1'b0;
    bus.br_take = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    clr_redirect();
    bus.br_target   = 32'd0;
    bus.jump_target = 32'd0;
    bus.jr_addr     = 32'd0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'd0;
    tick();
    tick();

    // reset state; late ack during reset must not leak through
    chk("rst_req",   {31'd0, bus.imem_req},    32'd0);
    chk("rst_addr",  bus.imem_addr,            32'd0);
    chk("rst_instr", bus.if_id_instr,          32'd0);
    chk("rst_pc4",   bus.if_id_pc4,            32'd0);
    chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("rst_err",   {31'd0, bus.fetch_err},   32'd0);

    // memory acks every request
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h8C220004;
    rst = 1'b0;
    tick();                                    // edge1
    chk("c1_req",  {31'd0, bus.imem_req},    32'd1);
    chk("c1_addr", bus.imem_addr,            32'd0);
    chk("c1_valid",{31'd0, bus.if_id_valid}, 32'd0);
    tick();                                    // edge2
    chk("c2_valid", {31'd0, bus.if_id_valid}, 32'd1);
    chk("c2_pc4",   bus.if_id_pc4,            32'h4);
    chk("c2_instr", bus.if_id_instr,          32'h8C220004);
    chk("c2_op",    {26'd0, bus.opcode},      32'd35);
    chk("c2_addr",  bus.imem_addr,            32'h4);
    tick();                                    // edge3
    tick();                                    // edge4
    bus.imem_ack = 1'b0;
    chk("c4_pc4",  bus.if_id_pc4,  32'h8);
    chk("c4_addr", bus.imem_addr,  32'h8);

    // stall with ack: word goes to skid buffer
    tick();                                    // edge5, S_WAIT
    bus.stall      = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h01095020;
    tick();                                    // edge6, captured
    bus.imem_ack = 1'b0;
    chk("hold_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("hold_instr", bus.if_id_instr,       32'h8C220004);
    chk("hold_pc4",   bus.if_id_pc4,         32'h8);
    chk("hold_addr",  bus.imem_addr,         32'hC);
    tick();
    tick();                                    // edge8
    chk("hold3_req",   {31'd0, bus.imem_req},    32'd0);
    chk("hold3_instr", bus.if_id_instr,          32'h8C220004);
    chk("hold3_valid", {31'd0, bus.if_id_valid}, 32'd1);
    bus.stall = 1'b0;
    tick();                                    // edge9, drain
    chk("drain_funct", {26'd0, bus.funct},  32'h20);
    chk("drain_instr", bus.if_id_instr,     32'h01095020);
    chk("drain_pc4",   bus.if_id_pc4,       32'hC);
    chk("drain_req",   {31'd0, bus.imem_req}, 32'd1);

    // all three redirects at once, under stall
    bus.stall       = 1'b1;
    bus.jumpr       = 1'b1;
    bus.jr_addr     = 32'h40;
    bus.jump        = 1'b1;
    bus.jump_target = 32'h80;
    bus.br_take     = 1'b1;
    bus.br_target   = 32'hC0;
    tick();                                    // edge10
    chk("prio_addr",  bus.imem_addr,            32'h40);
    chk("prio_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("prio_instr", bus.if_id_instr,          32'd0);
    chk("prio_op",    {26'd0, bus.opcode},      32'd0);
    chk("prio_funct", {26'd0, bus.funct},       32'd0);
    bus.stall       = 1'b0;
    bus.jumpr       = 1'b0;
    bus.jump_target = 32'h87;
    tick();                                    // edge11, jump beats branch, masked
    chk("jmp_addr", bus.imem_addr, 32'h84);
    clr_redirect();

    // branch while waiting, stale ack one cycle later
    tick();                                    // edge12, S_WAIT
    bus.br_take   = 1'b1;
    bus.br_target = 32'h100;
    tick();                                    // edge13
    clr_redirect();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEADBEEF;
    tick();                                    // edge14
    bus.imem_ack = 1'b0;
    chk("drop1_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("drop1_instr", bus.if_id_instr,          32'd0);
    chk("drop1_addr",  bus.imem_addr,            32'h100);
    tick();                                    // edge15
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h3C010001;
    tick();                                    // edge16
    bus.imem_ack = 1'b0;
    chk("refetch_instr", bus.if_id_instr, 32'h3C010001);
    chk("refetch_pc4",   bus.if_id_pc4,   32'h104);

    // branch while waiting, stale ack lands in the reissue's S_WAIT
    tick();                                    // edge17, S_WAIT
    bus.br_take   = 1'b1;
    bus.br_target = 32'h300;
    tick();                                    // edge18
    clr_redirect();
    tick();                                    // edge19, S_WAIT
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hAAAA0000;
    tick();                                    // edge20, discarded
    bus.imem_ack = 1'b0;
    chk("drop2_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("drop2_addr",  bus.imem_addr,            32'h300);
    tick();                                    // edge21
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h8C220004;
    tick();                                    // edge22
    bus.imem_ack = 1'b0;
    chk("drop2_pc4",   bus.if_id_pc4,            32'h304);
    chk("drop2_live",  {31'd0, bus.if_id_valid}, 32'd1);

    // pc+4 wrap
    bus.jump        = 1'b1;
    bus.jump_target = 32'hFFFFFFFF;
    tick();                                    // edge23
    clr_redirect();
    chk("wrap_addr0", bus.imem_addr, 32'hFFFFFFFC);
    tick();                                    // edge24
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h11111111;
    tick();                                    // edge25
    bus.imem_ack = 1'b0;
    chk("wrap_pc4",  bus.if_id_pc4, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // no ack for a long time
    tick();                                    // edge26, S_WAIT
    for (int i = 0; i < 14; i++) tick();       // edge40
    chk("to_early_err", {31'd0, bus.fetch_err}, 32'd0);
    tick();                                    // edge41
    chk("to_err",  {31'd0, bus.fetch_err}, {31'd0, TO_EN});
    chk("to_req",  {31'd0, bus.imem_req},  32'd1);
    chk("to_addr", bus.imem_addr,          32'h0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h22222222;
    begin : wait_load
      bit got;
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
        tick();
        if (bus.if_id_pc4 == 32'h4) got = 1'b1;
      end
      bus.imem_ack = 1'b0;
      chk("to_load_seen", {31'd0, got}, 32'd1);
    end
    chk("to_instr",     bus.if_id_instr,         32'h22222222);
    chk("to_err_stick", {31'd0, bus.fetch_err},  {31'd0, TO_EN});

    // reset mid-fetch, then a late ack
    tick();                                    // S_WAIT at pc 4
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req",   {31'd0, bus.imem_req},    32'd0);
    chk("mid_rst_addr",  bus.imem_addr,            32'd0);
    chk("mid_rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("mid_rst_err",   {31'd0, bus.fetch_err},   32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h33333333;
    tick();
    rst = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("late_ack_instr", bus.if_id_instr,          32'd0);
    chk("late_ack_req",   {31'd0, bus.imem_req},    32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-002 Ports (name direction width meaning) SHALL be:
- stall  in  1  hazard unit holds the IF/ID register
- br_take  in  1  Branch AND zero from EX
- br_target  in  32  branch target
- jump  in  1  Jump and not JumpR
- jump_target  in  32  jump target
- jumpr  in  1  JumpR
- jr_addr  in  32  register jump target
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  word-aligned fetch address
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- if_id_instr  out  32  IF/ID instruction
- if_id_pc4  out  32  IF/ID PC+4
- if_id_valid  out  1  IF/ID holds a live instruction
- opcode  out  6  if_id_instr[31:26], to the control decoder
- funct  out  6  if_id_instr[5:0], to the control decoder
- fetch_err  out  1  fetch timeout (REQ-019)

Function
REQ-003 pc SHALL be a 32-bit register; imem_addr SHALL equal pc; pc[1:0] SHALL always be 0, with redirect addresses masked to bits [31:2].
REQ-004 The FSM SHALL have three states:
- S_REQ: imem_req=1
- S_WAIT: imem_req=1, waiting for imem_ack
- S_HOLD: instruction in the skid buffer, imem_req=0
REQ-005 S_REQ SHALL go to S_WAIT on the next edge; S_WAIT on imem_ack SHALL go to S_REQ if the IF/ID load is permitted, else to S_HOLD; S_HOLD SHALL go to S_REQ on the first cycle with stall=0.
REQ-006 A permitted ack (stall=0, no redirect) SHALL, at the same edge, load if_id_instr=imem_rdata, if_id_pc4=pc+4, if_id_valid=1, and pc=pc+4; latency SHALL be 2 cycles from request to IF/ID.
REQ-007 An ack during stall=1 SHALL be captured in a one-entry skid buffer, with pc+4 applied at capture; the buffer SHALL drain into IF/ID on the first cycle with stall=0.
REQ-008 While stall=1, if_id_instr, if_id_pc4 and if_id_valid SHALL hold their values.
REQ-009 Redirect priority SHALL be jumpr > jump > br_take; the selected target SHALL load into pc at the edge it is seen, and the FSM SHALL go to S_REQ.
REQ-010 A redirect SHALL flush regardless of stall: if_id_instr=0 (NOP), if_id_valid=0, and skid buffer invalidated.
REQ-011 An ack in the same cycle as a redirect SHALL be discarded.
REQ-012 If a redirect occurs in S_WAIT, the next ack SHALL be discarded and the FSM SHALL reissue from the new pc; a one-bit drop_next flag SHALL track this.
REQ-013 pc+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000) with no flag.
REQ-014 opcode and funct SHALL be combinational slices of if_id_instr; a flushed slot SHALL present opcode=0, funct=0 (decoded as NOP).

Reset
REQ-015 While rst=1, outputs SHALL be: pc=0, imem_req=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_err=0; skid buffer and drop_next cleared; state S_REQ.
REQ-016 On the first edge after rst falls, the block SHALL assert imem_req with imem_addr=0.
REQ-017 Reset asserted mid-fetch SHALL abandon the transaction; a late ack after reset release SHALL be ignored until a request has been issued.

Configuration
REQ-018 Macro IF_FETCH_TIMEOUT_EN SHALL select the fetch-timeout feature.
REQ-019 When IF_FETCH_TIMEOUT_EN is defined: a 4-bit counter SHALL count cycles in S_WAIT; on reaching 15 it SHALL set fetch_err=1 (sticky until rst), and the FSM SHALL return to S_REQ to reissue the same pc.
REQ-020 When IF_FETCH_TIMEOUT_EN is undefined: fetch_err SHALL be constant 0, no counter SHALL exist, and S_WAIT SHALL wait indefinitely.

Verification
REQ-021 Reset release, memory acks every request with rdata=0x8C220004 -> first IF/ID valid at cycle 2 with pc4=0x4, opcode=35; pc increments by 4 thereafter.
REQ-022 stall=1 for 3 cycles while an ack (0x01095020) arrives -> IF/ID unchanged, imem_req=0 in S_HOLD; the skid word reaches IF/ID one cycle after stall=0, funct=0x20.
REQ-023 jumpr=1 (jr_addr=0x40), jump=1 (0x80) and br_take=1 (0xC0) in the same cycle -> pc=0x40, if_id_valid=0, if_id_instr=0.
REQ-024 br_take=1 to 0x100 while in S_WAIT, with the ack arriving one cycle later -> ack discarded, next imem_addr=0x100.
REQ-025 pc=0xFFFFFFFC, ack -> if_id_pc4=0x0, next imem_addr=0x0.
REQ-026 With IF_FETCH_TIMEOUT_EN defined and no ack for 15 cycles -> fetch_err=1, the same imem_addr is reissued, and fetch_err stays 1 after a later ack.
